// File: rtl/ip_pkg.sv
// IPv4 header constants, protocol numbers and framer state encoding.
// Shared by the framer, the checksum unit and the matching deframer.
package ip_pkg;

  localparam int          AXIS_BYTES    = 4;
  localparam int          IP_HDR_BYTES  = 20;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_FLAGS_DF   = 8'h40;
  localparam logic [7:0]  IP_PROTO_ICMP = 8'd1;
  localparam logic [7:0]  IP_PROTO_TCP  = 8'd6;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CKSUM,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_HDR4,
    ST_PAYLOAD
  } ip_state_e;

endpackage

// File: rtl/ip_checksum.sv
// Registered ones'-complement checksum over N 16-bit words; result updates one cycle after i_en.
// No backpressure: the caller holds i_words stable in the cycle i_en is high.
module ip_checksum #(
  parameter int N = 9
) (
  input  logic            clk,
  input  logic            sresetn,
  input  logic            i_en,
  input  logic [16*N-1:0] i_words,
  output logic [15:0]     o_cksum
);

  logic [31:0] w_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;
  logic [15:0] r_cksum;

  // Two folds suffice: the first leaves at most one carry, the second absorbs it.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = w_sum + 32'(i_words[16*i +: 16]);
    end
    w_fold1 = {1'b0, w_sum[15:0]} + {1'b0, w_sum[31:16]};
    w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      r_cksum <= '0;
    end else if (i_en) begin
      r_cksum <= ~w_fold2;
    end
  end

  assign o_cksum = r_cksum;

endmodule

// File: rtl/ip_framer.sv
// IPv4 TX encapsulator: 20-byte header then payload; first header beat 2 cycles after tvalid in IDLE.
// Header beats stall on axis_o_tready; payload is a combinational passthrough of valid/ready.
module ip_framer
  import ip_pkg::*;
#(
  parameter logic [7:0] TTL = 8'd64
) (
  input  logic        clk,
  input  logic        sresetn,
  input  logic        axis_i_tvalid,
  output logic        axis_i_tready,
  input  logic [31:0] axis_i_tdata,
  input  logic [3:0]  axis_i_tkeep,
  input  logic        axis_i_tlast,
  input  logic [15:0] axis_i_length,
  input  logic [7:0]  axis_i_protocol,
  input  logic [31:0] axis_i_src_ip,
  input  logic [31:0] axis_i_dst_ip,
  output logic        axis_o_tvalid,
  input  logic        axis_o_tready,
  output logic [31:0] axis_o_tdata,
  output logic [3:0]  axis_o_tkeep,
  output logic        axis_o_tlast
);

  ip_state_e   r_state;
  ip_state_e   w_state_nxt;
  logic [15:0] r_total_len;
  logic [7:0]  r_proto;
  logic [31:0] r_src_ip;
  logic [31:0] r_dst_ip;
  logic [15:0] r_id;
  logic [15:0] w_cksum;
  logic [143:0] w_words;
  logic        w_hdr_beat;
  logic [31:0] w_hdr_dat;

  // IP addresses arrive in wire byte order, so swap bytes to get big-endian header words.
  assign w_words = {
    {IP_VER_IHL, 8'h00},
    r_total_len,
    r_id,
    {IP_FLAGS_DF, 8'h00},
    {TTL, r_proto},
    {r_src_ip[7:0],   r_src_ip[15:8]},
    {r_src_ip[23:16], r_src_ip[31:24]},
    {r_dst_ip[7:0],   r_dst_ip[15:8]},
    {r_dst_ip[23:16], r_dst_ip[31:24]}
  };

  ip_checksum #(.N(9)) u_cksum (
    .clk     (clk),
    .sresetn (sresetn),
    .i_en    (r_state == ST_CKSUM),
    .i_words (w_words),
    .o_cksum (w_cksum)
  );

  always_comb begin
    w_hdr_beat = 1'b1;
    w_hdr_dat  = '0;
    case (r_state)
      ST_HDR0: w_hdr_dat = {r_total_len[7:0], r_total_len[15:8], 8'h00, IP_VER_IHL};
      ST_HDR1: w_hdr_dat = {8'h00, IP_FLAGS_DF, r_id[7:0], r_id[15:8]};
      ST_HDR2: w_hdr_dat = {w_cksum[7:0], w_cksum[15:8], r_proto, TTL};
      ST_HDR3: w_hdr_dat = r_src_ip;
      ST_HDR4: w_hdr_dat = r_dst_ip;
      default: w_hdr_beat = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    axis_i_tready = 1'b0;
    axis_o_tvalid = 1'b0;
    axis_o_tdata  = '0;
    axis_o_tkeep  = '0;
    axis_o_tlast  = 1'b0;
    if (w_hdr_beat) begin
      axis_o_tvalid = 1'b1;
      axis_o_tdata  = w_hdr_dat;
      axis_o_tkeep  = 4'hF;
    end
    case (r_state)
      ST_IDLE:  if (axis_i_tvalid) w_state_nxt = ST_CKSUM;
      ST_CKSUM: w_state_nxt = ST_HDR0;
      ST_HDR0:  if (axis_o_tready) w_state_nxt = ST_HDR1;
      ST_HDR1:  if (axis_o_tready) w_state_nxt = ST_HDR2;
      ST_HDR2:  if (axis_o_tready) w_state_nxt = ST_HDR3;
      ST_HDR3:  if (axis_o_tready) w_state_nxt = ST_HDR4;
      ST_HDR4:  if (axis_o_tready) w_state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: begin
        axis_o_tvalid = axis_i_tvalid;
        axis_o_tdata  = axis_i_tdata;
        axis_o_tkeep  = axis_i_tkeep;
        axis_o_tlast  = axis_i_tlast;
        axis_i_tready = axis_o_tready;
        if (axis_i_tvalid && axis_o_tready && axis_i_tlast) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      r_state     <= ST_IDLE;
      r_total_len <= '0;
      r_proto     <= '0;
      r_src_ip    <= '0;
      r_dst_ip    <= '0;
      r_id        <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Sideband is captured once per frame; the first beat stays unconsumed until PAYLOAD.
      if (r_state == ST_IDLE && axis_i_tvalid) begin
        r_total_len <= axis_i_length + 16'(IP_HDR_BYTES);
        r_proto     <= axis_i_protocol;
        r_src_ip    <= axis_i_src_ip;
        r_dst_ip    <= axis_i_dst_ip;
      end
      if (r_state == ST_PAYLOAD && axis_i_tvalid && axis_o_tready && axis_i_tlast) begin
        r_id <= r_id + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ip_framer.sv
// Self-checking bench for ip_framer: directed header table, randomized frames vs a byte-level model,
// plus hand sequences for latency and mid-header reset.
module tb_ip_framer;

  logic        clk = 1'b0;
  logic        sresetn;
  logic        i_tvalid, i_tready, i_tlast;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic [15:0] i_len;
  logic [7:0]  i_proto;
  logic [31:0] i_src, i_dst;
  logic        o_tvalid, o_tready, o_tlast;
  logic [31:0] o_tdata;
  logic [3:0]  o_tkeep;

  always #5 clk = ~clk;

  ip_framer dut (
    .clk             (clk),
    .sresetn         (sresetn),
    .axis_i_tvalid   (i_tvalid),
    .axis_i_tready   (i_tready),
    .axis_i_tdata    (i_tdata),
    .axis_i_tkeep    (i_tkeep),
    .axis_i_tlast    (i_tlast),
    .axis_i_length   (i_len),
    .axis_i_protocol (i_proto),
    .axis_i_src_ip   (i_src),
    .axis_i_dst_ip   (i_dst),
    .axis_o_tvalid   (o_tvalid),
    .axis_o_tready   (o_tready),
    .axis_o_tdata    (o_tdata),
    .axis_o_tkeep    (o_tkeep),
    .axis_o_tlast    (o_tlast)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit stall_mode = 1'b0;
  logic [36:0] exp_q[$];
  logic [15:0] exp_id;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask

  // Reference: build the 20 header bytes in wire order, checksum pairs of bytes, pack 4 bytes per beat.
  function automatic logic [159:0] ref_hdr(input logic [15:0] len, input logic [7:0] proto,
                                           input logic [31:0] src, input logic [31:0] dst,
                                           input logic [15:0] id);
    logic [7:0]  b[20];
    logic [15:0] tl;
    logic [15:0] ck;
    int unsigned sum;
    logic [159:0] r;
    tl = len + 16'd20;
    b[0] = 8'h45;     b[1] = 8'h00;    b[2] = tl[15:8];  b[3] = tl[7:0];
    b[4] = id[15:8];  b[5] = id[7:0];  b[6] = 8'h40;     b[7] = 8'h00;
    b[8] = 8'd64;     b[9] = proto;    b[10] = 8'h00;    b[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      b[12+i] = src[8*i +: 8];
      b[16+i] = dst[8*i +: 8];
    end
    sum = 0;
    for (int i = 0; i < 10; i++) sum += {16'd0, b[2*i], b[2*i+1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    ck = ~sum[15:0];
    b[10] = ck[15:8];
    b[11] = ck[7:0];
    for (int n = 0; n < 5; n++) r[32*n +: 32] = {b[4*n+3], b[4*n+2], b[4*n+1], b[4*n]};
    return r;
  endfunction

  task automatic finish_now();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Drives one frame; sideband is scrambled on every beat after the first.
  task automatic run_frame(input logic [15:0] len, input logic [7:0] proto,
                           input logic [31:0] src, input logic [31:0] dst,
                           input logic [159:0] hdr);
    int nb, rem, cnt;
    logic [31:0] d;
    logic [3:0]  k;
    nb  = (int'(len) + 3) / 4;
    rem = int'(len) % 4;
    for (int n = 0; n < 5; n++) exp_q.push_back({hdr[32*n +: 32], 4'hF, 1'b0});
    for (int bt = 0; bt < nb; bt++) begin
      d = $urandom;
      k = (bt == nb - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
      exp_q.push_back({d, k, bt == nb - 1});
      i_tvalid = 1'b1;
      i_tdata  = d;
      i_tkeep  = k;
      i_tlast  = (bt == nb - 1);
      if (bt == 0) begin
        i_len = len; i_proto = proto; i_src = src; i_dst = dst;
      end else begin
        i_len = 16'($urandom); i_proto = 8'($urandom); i_src = $urandom; i_dst = $urandom;
      end
      cnt = 0;
      forever begin
        #1;
        if (i_tready) begin
          @(negedge clk);
          break;
        end
        @(negedge clk);
        cnt++;
        if (cnt > 500) begin
          checks++;
          errors++;
          $display("FAIL in_accept_timeout got no tready want tready within 500 cycles");
          finish_now();
        end
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Output monitor / scoreboard with optional random backpressure.
  logic        prev_stall = 1'b0;
  logic [36:0] prev_beat;
  logic [36:0] got, want;
  always begin
    @(negedge clk);
    o_tready = mon_en ? (stall_mode ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b1;
    #1;
    if (mon_en && sresetn) begin
      got = {o_tdata, o_tkeep, o_tlast};
      if (prev_stall) begin
        chk("stall_vld", 64'(o_tvalid), 64'd1);
        chk("stall_dat", 64'(got), 64'(prev_beat));
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat got %h want no beat", got);
        end else begin
          want = exp_q.pop_front();
          chk("beat", 64'(got), 64'(want));
        end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_beat  = got;
    end else begin
      prev_stall = 1'b0;
    end
  end

  typedef struct {
    logic [15:0]  len;
    logic [7:0]   proto;
    logic [31:0]  src;
    logic [31:0]  dst;
    bit           stall;
    logic [159:0] hdr;
  } vec_t;

  vec_t tbl[3];
  logic [7:0] protos[3];
  logic [159:0] h;
  logic [15:0] rl;
  logic [7:0] rp;
  logic [31:0] rs, rd;

  initial begin
    tbl[0] = '{16'd8, 8'd17, 32'h0100A8C0, 32'h0200A8C0, 1'b0,
               {32'h0200A8C0, 32'h0100A8C0, 32'h7DB91140, 32'h00400000, 32'h1C000045}};
    tbl[1] = '{16'd1, 8'd17, 32'h0100A8C0, 32'h0200A8C0, 1'b0,
               {32'h0200A8C0, 32'h0100A8C0, 32'h83B91140, 32'h00400100, 32'h15000045}};
    tbl[2] = '{16'd8, 8'd17, 32'h0100A8C0, 32'h0200A8C0, 1'b1,
               {32'h0200A8C0, 32'h0100A8C0, 32'h7BB91140, 32'h00400200, 32'h1C000045}};
    protos[0] = 8'd1; protos[1] = 8'd6; protos[2] = 8'd17;

    sresetn = 1'b0;
    i_tvalid = 1'b0; i_tdata = '0; i_tkeep = '0; i_tlast = 1'b0;
    i_len = '0; i_proto = '0; i_src = '0; i_dst = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_i_tready", 64'(i_tready), 64'd0);
    @(negedge clk);
    sresetn = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    // Directed frames: ids 0,1,2 with hand-computed headers.
    for (int i = 0; i < 3; i++) begin
      stall_mode = tbl[i].stall;
      run_frame(tbl[i].len, tbl[i].proto, tbl[i].src, tbl[i].dst, tbl[i].hdr);
      wait_drain();
    end
    exp_id = 16'd3;

    // Back-to-back randomized frames against the model.
    for (int f = 0; f < 30; f++) begin
      stall_mode = (f >= 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      rl = 16'($urandom_range(1, 64));
      rp = protos[$urandom_range(0, 2)];
      rs = $urandom;
      rd = $urandom;
      h  = ref_hdr(rl, rp, rs, rd, exp_id);
      run_frame(rl, rp, rs, rd, h);
      exp_id = exp_id + 16'd1;
    end
    wait_drain();

    // Latency and reset during HDR2.
    stall_mode = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    h = ref_hdr(16'd8, 8'd17, 32'h0100A8C0, 32'h0200A8C0, exp_id);
    i_tvalid = 1'b1; i_tdata = 32'hA5A5A5A5; i_tkeep = 4'hF; i_tlast = 1'b0;
    i_len = 16'd8; i_proto = 8'd17; i_src = 32'h0100A8C0; i_dst = 32'h0200A8C0;
    #1;
    chk("lat_idle_vld", 64'(o_tvalid), 64'd0);
    @(negedge clk); #1;
    chk("lat_cksum_vld", 64'(o_tvalid), 64'd0);
    @(negedge clk); #1;
    chk("lat_hdr0_vld", 64'(o_tvalid), 64'd1);
    chk("lat_hdr0_dat", 64'(o_tdata), 64'(h[31:0]));
    @(negedge clk);
    @(negedge clk); #1;
    chk("hdr2_dat", 64'(o_tdata), 64'(h[95:64]));
    sresetn = 1'b0;
    @(negedge clk); #1;
    chk("midrst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("midrst_i_tready", 64'(i_tready), 64'd0);
    sresetn = 1'b1;
    i_tvalid = 1'b0;
    repeat (2) @(negedge clk);

    // After reset the identification counter restarts at 0.
    mon_en = 1'b1;
    exp_id = 16'd0;
    h = ref_hdr(16'd8, 8'd17, 32'h0100A8C0, 32'h0200A8C0, exp_id);
    chk("model_hdr1_id0", 64'(h[63:32]), 64'h00400000);
    run_frame(16'd8, 8'd17, 32'h0100A8C0, 32'h0200A8C0, h);
    wait_drain();

    finish_now();
  end

endmodule
